wb_merge_arb: RTL and testbench

- Two-input to one-output merge unit: the inverse of the 32-bit result demux.
- Collects results from two producers (A: ALU path, B: load/memory path) onto the single register-file write port.
- Valid/ready handshake on every channel.
- Round-robin arbitration and a registered output stage, so the write port sees one result per cycle at full throughput.

---
 rtl/wb_merge_if.sv | 38 +++
 rtl/wb_merge_arb.sv | 89 ++++++++
 tb/tb_wb_merge_arb.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/wb_merge_if.sv
// Bus bundle for wb_merge_arb: two producer channels (A, B) and the merged
// register-file write channel, each with valid/ready.
interface wb_merge_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          a_valid;
    logic          a_ready;
    logic [DW-1:0] a_data;
    logic [RW-1:0] a_rd;
    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] b_data;
    logic [RW-1:0] b_rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_rd;
    logic          out_sel;

    // Merge unit side.
    modport slave (
        input  a_valid, a_data, a_rd,
        input  b_valid, b_data, b_rd,
        input  out_ready,
        output a_ready, b_ready,
        output out_valid, out_data, out_rd, out_sel
    );

    // Producer / write-port side.
    modport master (
        output a_valid, a_data, a_rd,
        output b_valid, b_data, b_rd,
        output out_ready,
        input  a_ready, b_ready,
        input  out_valid, out_data, out_rd, out_sel
    );
endinterface

// File: rtl/wb_merge_arb.sv
// Merges ALU (A) and load (B) results onto one register-file write port via a
// registered output stage. Define WB_MERGE_FIXED_PRIO_EN for A-first fixed priority.
module wb_merge_arb #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_merge_if.slave bus
);

    // Handshake: a channel transfers on a rising edge where valid & ready are
    // both high. Ready may follow valid combinationally; valid never follows
    // ready. A producer holds valid and payload stable until accepted.

    logic          load;
    logic          gnt_a;
    logic          gnt_b;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic [RW-1:0] out_rd_q;
    logic          out_sel_q;

    assign load = ~out_valid_q | bus.out_ready;

`ifdef WB_MERGE_FIXED_PRIO_EN
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (load) begin
            gnt_a = bus.a_valid;
            gnt_b = bus.b_valid & ~bus.a_valid;
        end
    end
`else
    // 0 = A, 1 = B; reset to B so A wins the first tie.
    logic last_grant;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (load) begin
            if (bus.a_valid && bus.b_valid) begin
                gnt_a = last_grant;
                gnt_b = ~last_grant;
            end else begin
                gnt_a = bus.a_valid;
                gnt_b = bus.b_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (gnt_a || gnt_b) begin
            last_grant <= gnt_b;
        end
    end
`endif

    assign bus.a_ready = gnt_a;
    assign bus.b_ready = gnt_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_sel_q   <= 1'b0;
        end else if (load) begin
            if (gnt_a || gnt_b) begin
                out_valid_q <= 1'b1;
                out_data_q  <= gnt_b ? bus.b_data : bus.a_data;
                out_rd_q    <= gnt_b ? bus.b_rd : bus.a_rd;
                out_sel_q   <= gnt_b;
            end else begin
                // Drained with nothing to replace it: payload holds, valid drops.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_wb_merge_arb.sv
// Directed bench for wb_merge_arb: reset, single transfers, alternation,
// output stall, back-to-back throughput, mid-run reset and tie order.
module tb_wb_merge_arb;

`ifdef WB_MERGE_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   ai;
    int   bi;
    logic exp_b;

    wb_merge_if #(.DW(32), .RW(5)) bus ();

    wb_merge_arb #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.a_valid = 1'b0; bus.a_data = '0; bus.a_rd = '0;
        bus.b_valid = 1'b0; bus.b_data = '0; bus.b_rd = '0;
        bus.out_ready = 1'b0;

        #3;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_rd", bus.out_rd, 0);
        chk("rst_out_sel", bus.out_sel, 0);
        #9 rst_n = 1'b1;
        tick();

        // Single A transfer.
        bus.a_valid = 1'b1; bus.a_data = 32'h1234_5678; bus.a_rd = 5'd3; bus.out_ready = 1'b1;
        #1;
        chk("t1_a_ready", bus.a_ready, 1);
        chk("t1_b_ready", bus.b_ready, 0);
        tick();
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_data", bus.out_data, 32'h1234_5678);
        chk("t1_out_rd", bus.out_rd, 3);
        chk("t1_out_sel", bus.out_sel, 0);
        bus.a_valid = 1'b0;
        tick();
        chk("t1_drain_valid", bus.out_valid, 0);
        chk("t1_drain_data_hold", bus.out_data, 32'h1234_5678);

        // Single B transfer; leaves last grant on B.
        bus.b_valid = 1'b1; bus.b_data = 32'h0000_0BFF; bus.b_rd = 5'd7;
        #1;
        chk("tb_b_ready", bus.b_ready, 1);
        chk("tb_a_ready", bus.a_ready, 0);
        tick();
        chk("tb_out_data", bus.out_data, 32'h0000_0BFF);
        chk("tb_out_rd", bus.out_rd, 7);
        chk("tb_out_sel", bus.out_sel, 1);

        // Both valid for 6 cycles: A0, B0, A1, B1, A2, B2.
        ai = 0; bi = 0;
        for (int k = 0; k < 6; k++) begin
            bus.a_valid = 1'b1; bus.b_valid = 1'b1;
            bus.a_data = 32'hA0 + ai; bus.b_data = 32'hB0 + bi;
            bus.a_rd = 5'd1; bus.b_rd = 5'd2;
            exp_b = FIXED ? 1'b0 : k[0];
            #1;
            chk("alt_a_ready", bus.a_ready, !exp_b);
            chk("alt_b_ready", bus.b_ready, exp_b);
            tick();
            chk("alt_out_data", bus.out_data, exp_b ? 32'hB0 + bi : 32'hA0 + ai);
            chk("alt_out_sel", bus.out_sel, exp_b);
            if (exp_b) bi++; else ai++;
        end

        // Load 0xCAFE0001 from A, then stall the write port.
        bus.b_valid = 1'b0; bus.a_data = 32'hCAFE_0001; bus.a_rd = 5'd9;
        #1;
        chk("cafe_a_ready", bus.a_ready, 1);
        tick();
        chk("cafe_out_data", bus.out_data, 32'hCAFE_0001);
        bus.out_ready = 1'b0;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        bus.a_data = 32'hA9; bus.b_data = 32'hB9;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_a_ready", bus.a_ready, 0);
            chk("stall_b_ready", bus.b_ready, 0);
            tick();
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_out_data", bus.out_data, 32'hCAFE_0001);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("unstall_b_ready", bus.b_ready, !FIXED);
        chk("unstall_a_ready", bus.a_ready, FIXED);
        tick();
        chk("unstall_out_data", bus.out_data, FIXED ? 32'hA9 : 32'hB9);
        chk("unstall_out_sel", bus.out_sel, !FIXED);

        // A back-to-back 1..4, no bubbles.
        bus.b_valid = 1'b0; bus.a_valid = 1'b1; bus.a_rd = 5'd5;
        for (int i = 1; i <= 4; i++) begin
            bus.a_data = i;
            #1;
            chk("b2b_a_ready", bus.a_ready, 1);
            tick();
            chk("b2b_out_valid", bus.out_valid, 1);
            chk("b2b_out_data", bus.out_data, i);
        end
        bus.a_valid = 1'b0;
        tick();
        chk("b2b_tail_valid", bus.out_valid, 0);

        // Reset pulse between edges while a result is held.
        bus.a_valid = 1'b1; bus.a_data = 32'h55; bus.a_rd = 5'd4;
        tick();
        bus.a_valid = 1'b0; bus.out_ready = 1'b0;
        chk("pre_rst_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_rd", bus.out_rd, 0);
        #2 rst_n = 1'b1;
        tick();
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        bus.a_data = 32'h77; bus.b_data = 32'h88; bus.out_ready = 1'b1;
        #1;
        chk("post_rst_a_ready", bus.a_ready, 1);
        chk("post_rst_b_ready", bus.b_ready, 0);
        tick();
        chk("post_rst_out_data", bus.out_data, 32'h77);
        chk("post_rst_out_sel", bus.out_sel, 0);

        // Tie for 4 cycles after an A grant, then drop A.
        ai = 0; bi = 0;
        for (int k = 0; k < 4; k++) begin
            bus.a_data = 32'h60 + ai; bus.b_data = 32'h70 + bi;
            exp_b = FIXED ? 1'b0 : !k[0];
            #1;
            chk("tie_a_ready", bus.a_ready, !exp_b);
            chk("tie_b_ready", bus.b_ready, exp_b);
            tick();
            chk("tie_out_data", bus.out_data, exp_b ? 32'h70 + bi : 32'h60 + ai);
            if (exp_b) bi++; else ai++;
        end
        bus.a_valid = 1'b0; bus.b_data = 32'h70 + bi;
        #1;
        chk("drop_a_b_ready", bus.b_ready, 1);
        tick();
        chk("drop_a_out_data", bus.out_data, 32'h70 + bi);
        chk("drop_a_out_sel", bus.out_sel, 1);
        bus.b_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
